// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LEAD,
      ST_XFER,
      ST_TRAIL
   } state_e;

   // SPI mode number is {cpol, cpha}
   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_e;

   localparam int unsigned H_SEL0 = 1;
   localparam int unsigned H_SEL1 = 2;
   localparam int unsigned H_SEL2 = 8;
   localparam int unsigned H_SEL3 = 16;
   localparam int unsigned TICK_W = 4;

   // Half-period minus one, used as the tick counter reload value
   function automatic logic [TICK_W-1:0] half_period_m1(input logic [1:0] sel);
      logic [TICK_W-1:0] val;
      case (sel)
         2'd0:    val = TICK_W'(H_SEL0 - 1);
         2'd1:    val = TICK_W'(H_SEL1 - 1);
         2'd2:    val = TICK_W'(H_SEL2 - 1);
         default: val = TICK_W'(H_SEL3 - 1);
      endcase
      return val;
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response and SPI pin bundle for spi_master_ctrl.
interface spi_master_ctrl_if #(
   parameter int unsigned DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic              cpol;
   logic              cpha;
   logic [1:0]        clk_sel;
   logic              miso;
   logic              sclk;
   logic              mosi;
   logic              ss_n;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rx_data;

   modport master (
      input  start, tx_data, cpol, cpha, clk_sel, miso,
      output sclk, mosi, ss_n, busy, done, rx_data
   );

   modport slave (
      output start, tx_data, cpol, cpha, clk_sel, miso,
      input  sclk, mosi, ss_n, busy, done, rx_data
   );
endinterface

// File: rtl/spi_sclk_tick.sv
// Half-period tick generator: down-counter reloaded with H-1, one-cycle tick at zero.
module spi_sclk_tick
   import spi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [TICK_W-1:0] load_val,
   output logic              tick_c
);

   logic [TICK_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_c = !load && (cnt_q == '0);
      cnt_d  = cnt_q - TICK_W'(1);
      if (load || tick_c) cnt_d = load_val;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master frame sequencer: FSM, toggle counter, tx/rx shift registers, registered pins.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   spi_master_ctrl_if.master   bus
);

   localparam int unsigned    CNT_W  = $clog2(2 * DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(2 * DATA_W);

   state_e            state_q, state_d;
   spi_mode_e         mode_q, mode_d;
   logic [1:0]        sel_q, sel_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [CNT_W-1:0]  tgl_q, tgl_d;
   logic              arm_q, arm_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              ss_n_q, ss_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;

   logic              tick_c, load_c, cpol_c, cpha_c;
   logic              shift_c, capture_c;
   logic [CNT_W-1:0]  k_c;

   assign cpol_c = (mode_q == MODE2) || (mode_q == MODE3);
   assign cpha_c = (mode_q == MODE1) || (mode_q == MODE3);
   // Hold the counter for the accept cycle so toggle k lands at t0+1+k*H
   assign load_c = (state_q == ST_IDLE) || arm_q;

   spi_sclk_tick u_tick (
      .clk      (clk),
      .reset    (reset),
      .load     (load_c),
      .load_val (half_period_m1(sel_q)),
      .tick_c   (tick_c)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      sel_d     = sel_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      tgl_d     = tgl_q;
      arm_d     = 1'b0;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ss_n_d    = ss_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rx_data_d = rx_data_q;
      k_c       = tgl_q + CNT_W'(1);
      // Odd k is the leading edge
      shift_c   = cpha_c ? k_c[0] : (!k_c[0] && (k_c != LAST_K));
      capture_c = cpha_c ? !k_c[0] : k_c[0];

      case (state_q)
         ST_IDLE: begin
            sclk_d = bus.cpol;
            mosi_d = 1'b0;
            ss_n_d = 1'b1;
            if (bus.start) begin
               state_d = ST_LEAD;
               mode_d  = spi_mode_e'({bus.cpol, bus.cpha});
               sel_d   = bus.clk_sel;
               tx_sh_d = bus.cpha ? bus.tx_data : (bus.tx_data << 1);
               mosi_d  = bus.cpha ? 1'b0 : bus.tx_data[DATA_W-1];
               rx_sh_d = '0;
               tgl_d   = '0;
               arm_d   = 1'b1;
               ss_n_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_LEAD, ST_XFER: begin
            if (tick_c) begin
               sclk_d = ~sclk_q;
               tgl_d  = k_c;
               if (shift_c) begin
                  mosi_d  = tx_sh_q[DATA_W-1];
                  tx_sh_d = tx_sh_q << 1;
               end
               if (capture_c) rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.miso};
               state_d = (k_c == LAST_K) ? ST_TRAIL : ST_XFER;
            end
         end
         ST_TRAIL: begin
            if (tick_c) begin
               state_d   = ST_IDLE;
               sclk_d    = cpol_c;
               mosi_d    = 1'b0;
               ss_n_d    = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE0;
         sel_q     <= 2'd0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         tgl_q     <= '0;
         arm_q     <= 1'b0;
         sclk_q    <= bus.cpol;
         mosi_q    <= 1'b0;
         ss_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         sel_q     <= sel_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         tgl_q     <= tgl_d;
         arm_q     <= arm_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ss_n_q    <= ss_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.ss_n    = ss_n_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed + randomized frames against a timing-formula reference and a behavioural SPI slave.
module tb_spi_master_ctrl;

   localparam int unsigned D = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_master_ctrl_if #(.DATA_W(D)) bus ();

   spi_master_ctrl #(.DATA_W(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Behavioural slave state
   logic         loopback = 1'b0;
   logic [D-1:0] s_tx = '0;
   logic [D-1:0] s_rx = '0;
   int           s_idx = 0;
   int           s_samples = 0;
   int           stab_errs = 0;
   logic         f_cpol = 1'b1;
   logic         f_cpha = 1'b0;
   logic         sclk_prev = 1'b1;
   logic         ss_prev = 1'b1;
   logic         mosi_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave reacts half a cycle after each SCLK change, like a real device on the pins
   always @(negedge clk) begin
      logic leading;
      if (reset) begin
         bus.miso = 1'b0;
      end else begin
         if (ss_prev && !bus.ss_n) begin
            s_rx = '0;
            s_samples = 0;
            if (!f_cpha) begin
               bus.miso = s_tx[D-1];
               s_idx = D - 2;
            end else begin
               s_idx = D - 1;
            end
         end else if (!bus.ss_n && (bus.sclk !== sclk_prev)) begin
            leading = (bus.sclk !== f_cpol);
            if (leading ^ f_cpha) begin
               s_rx = {s_rx[D-2:0], bus.mosi};
               s_samples++;
               if (bus.mosi !== mosi_prev) stab_errs++;
            end else if (s_idx >= 0) begin
               bus.miso = s_tx[s_idx];
               s_idx--;
            end
         end
         if (loopback) bus.miso = bus.mosi;
      end
      sclk_prev = bus.sclk;
      ss_prev   = bus.ss_n;
      mosi_prev = bus.mosi;
   end

   task automatic run_frame(input string tag, input logic [1:0] mode, input logic [1:0] sel,
                            input logic [D-1:0] tx, input logic [D-1:0] stx, input bit lb,
                            input int repulse_n, input int reset_n, input bit flip, input bit hold);
      int h, nd, tg, done_n, done_cnt, ss_low;
      int sclk_errs, ss_errs, busy_errs, done_errs;
      logic exp_sclk, exp_ss, exp_busy;
      logic [D-1:0] exp_rx;
      bit seen;
      h  = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : (sel == 2'd2) ? 8 : 16;
      nd = 1 + (2 * D + 1) * h;
      exp_rx = lb ? tx : stx;
      sclk_errs = 0; ss_errs = 0; busy_errs = 0; done_errs = 0;
      done_n = -1; done_cnt = 0; ss_low = 0;

      @(negedge clk);
      f_cpol = mode[1]; f_cpha = mode[0]; s_tx = stx; loopback = lb; stab_errs = 0;
      bus.cpol = mode[1]; bus.cpha = mode[0]; bus.clk_sel = sel; bus.tx_data = tx;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) begin
         bus.start   = 1'b0;
         bus.tx_data = D'($urandom);
         bus.cpha    = 1'($urandom);
         bus.clk_sel = 2'($urandom);
      end

      for (int n = 0; n <= nd + 1; n++) begin
         @(negedge clk);
         if (n == repulse_n - 1) begin bus.start = 1'b1; bus.tx_data = ~tx; end
         if (n == repulse_n) bus.start = 1'b0;
         if (flip && n == 2) bus.cpol = ~f_cpol;
         if (flip && n == nd - 2) bus.cpol = f_cpol;
         if (reset_n > 0 && n == reset_n - 1) reset = 1'b1;
         if (reset_n > 0 && n == reset_n) begin
            check({tag, "_rst_ss_n"}, 32'(bus.ss_n), 32'd1);
            check({tag, "_rst_sclk"}, 32'(bus.sclk), 32'(f_cpol));
            check({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
            check({tag, "_rst_mosi"}, 32'(bus.mosi), 32'd0);
            check({tag, "_rst_rx"}, 32'(bus.rx_data), 32'd0);
            reset = 1'b0;
            for (int m = 0; m < 40; m++) begin
               @(negedge clk);
               if (bus.done) done_cnt++;
            end
            check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
            return;
         end
         tg = (n < 1) ? 0 : (n - 1) / h;
         if (tg > 2 * D) tg = 2 * D;
         exp_sclk = f_cpol ^ ((tg % 2) == 1);
         exp_ss   = (n > nd) ? !hold : (n == nd);
         exp_busy = !exp_ss;
         if (bus.sclk !== exp_sclk) sclk_errs++;
         if (bus.ss_n !== exp_ss) ss_errs++;
         if (bus.busy !== exp_busy) busy_errs++;
         if (n >= 1 && n <= nd && bus.ss_n === 1'b0) ss_low++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_n < 0) done_n = n;
         end
         if (n == nd) check({tag, "_mosi_idle"}, 32'(bus.mosi), 32'd0);
      end

      check({tag, "_sclk_wave"}, 32'(sclk_errs), 32'd0);
      check({tag, "_ss_n_wave"}, 32'(ss_errs), 32'd0);
      check({tag, "_busy_wave"}, 32'(busy_errs), 32'd0);
      check({tag, "_ss_low_cycles"}, 32'(ss_low), 32'(nd - 1));
      check({tag, "_done_cycle"}, 32'(done_n), 32'(nd));
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(exp_rx));
      check({tag, "_slave_rx"}, 32'(s_rx), 32'(tx));
      check({tag, "_slave_bits"}, 32'(s_samples), 32'(D));
      check({tag, "_mosi_stable"}, 32'(stab_errs), 32'd0);

      if (hold) begin
         bus.start = 1'b0;
         seen = 1'b0;
         for (int m = 0; m < nd + 4 && !seen; m++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
         end
         check({tag, "_retrigger_done"}, 32'(seen), 32'd1);
         check({tag, "_retrigger_rx"}, 32'(bus.rx_data), 32'(exp_rx));
      end
   endtask

   initial begin
      logic [1:0] rm;
      reset = 1'b1;
      bus.start = 1'b0; bus.tx_data = '0; bus.cpol = 1'b1; bus.cpha = 1'b0; bus.clk_sel = 2'd0;
      repeat (3) @(negedge clk);
      check("reset_sclk_cpol1", 32'(bus.sclk), 32'd1);
      check("reset_ss_n", 32'(bus.ss_n), 32'd1);
      check("reset_mosi", 32'(bus.mosi), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_rx", 32'(bus.rx_data), 32'd0);
      bus.cpol = 1'b0;
      @(negedge clk);
      check("reset_sclk_cpol0", 32'(bus.sclk), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_frame("m0_loop", 2'd0, 2'd0, 8'hA5, 8'h00, 1'b1, -10, 0, 1'b0, 1'b0);
      run_frame("m3_h16",  2'd3, 2'd3, 8'h3C, 8'hC3, 1'b0, -10, 0, 1'b0, 1'b0);
      run_frame("m1_h2",   2'd1, 2'd1, 8'h81, 8'h7E, 1'b0, -10, 0, 1'b0, 1'b0);
      run_frame("m2_h2",   2'd2, 2'd1, 8'h81, 8'h7E, 1'b0, -10, 0, 1'b0, 1'b0);
      run_frame("repulse", 2'd0, 2'd0, 8'h5A, 8'h96, 1'b0, 5, 0, 1'b0, 1'b0);
      run_frame("abort",   2'd1, 2'd0, 8'hE7, 8'h18, 1'b0, -10, 9, 1'b0, 1'b0);
      run_frame("post_abort", 2'd1, 2'd0, D'($urandom), D'($urandom), 1'b0, -10, 0, 1'b0, 1'b0);
      run_frame("hold",    2'd2, 2'd0, 8'h6C, 8'h93, 1'b0, -10, 0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         rm = 2'($urandom);
         run_frame($sformatf("rand%0d", i), rm, 2'($urandom_range(0, 2)), D'($urandom),
                   D'($urandom), 1'b0, -10, 0, (i % 2) == 1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
